// File: rtl/sum_accum_32.sv
// Streaming 32-bit summation of a counted operand burst, with a valid/ready result handshake.
// Optional sticky carry-out flag on port ovf when SUM_ACCUM_OVF_EN is defined.

module cla_32_final (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s
);
    logic [31:0] g, p, c;
    logic [7:0]  gg, pg, gc;

    // Eight 4-bit lookahead groups with a group-level carry chain.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        pg = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
        gc[0] = c_in;
        for (int k = 0; k < 7; k++) begin
            gc[k+1] = gg[k] | (pg[k] & gc[k]);
        end
        for (int i = 0; i < 32; i++) begin
            if (i % 4 == 0) c[i] = gc[i/4];
            else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        s = p ^ c;
    end
endmodule

module sum_accum_32 #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef SUM_ACCUM_OVF_EN
    ,
    output logic             ovf
`endif
);
    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [31:0]      acc_q, add_s;
    logic [LEN_W-1:0] cnt_q, len_q;
    logic             hs, last;

    assign hs   = in_valid & in_ready;
    assign last = (cnt_q == len_q - LEN_W'(1));

    cla_32_final u_add (
        .a    (acc_q),
        .b    (in_data),
        .c_in (1'b0),
        .s    (add_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (len == '0) ? StDone : StAcc;
            StAcc:   if (hs && last) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StDone);
        busy      = (state_q == StAcc) || (state_q == StDone);
        sum       = acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else if (state_q == StIdle && start) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= len;
        end else if (hs) begin
            acc_q <= add_s;
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

`ifdef SUM_ACCUM_OVF_EN
    logic ovf_q, carry;

    // The adder has no carry port, so recover carry-out of bit 31 from the MSBs.
    assign carry = (acc_q[31] & in_data[31]) | ((acc_q[31] ^ in_data[31]) & ~add_s[31]);
    assign ovf   = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ovf_q <= 1'b0;
        else if (state_q == StIdle && start) ovf_q <= 1'b0;
        else if (hs && carry)              ovf_q <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sum_accum_32.sv
// Randomised and directed bench for sum_accum_32 against a plain-arithmetic reference model.
// Checks ovf only when SUM_ACCUM_OVF_EN is defined.

module tb_sum_accum_32;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  len;
    logic [31:0] in_data;
    wire         in_ready, out_valid, busy;
    wire  [31:0] sum;
`ifdef SUM_ACCUM_OVF_EN
    wire         ovf;
`endif

    sum_accum_32 #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef SUM_ACCUM_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_sum;
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovf(input string tag);
`ifdef SUM_ACCUM_OVF_EN
        check(tag, {31'd0, ovf}, {31'd0, m_ovf});
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    task automatic start_txn(input int n);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'($urandom);
        m_sum = '0;
        m_ovf = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        if (n == 0) begin
            check("len0_in_ready", {31'd0, in_ready}, 32'd0);
            check("len0_out_valid", {31'd0, out_valid}, 32'd1);
            check("len0_sum", sum, 32'd0);
        end
    endtask

    task automatic feed(input logic [31:0] word, input int gap, input bit is_last);
        logic [32:0] wide;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            start    = $urandom_range(0, 1) == 1;
            len      = 8'd1;
            tick();
            start = 1'b0;
            check("gap_hold", sum, m_sum);
            check("gap_in_ready", {31'd0, in_ready}, 32'd1);
        end
        check("in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = word;
        tick();
        in_valid = 1'b0;
        wide  = {1'b0, m_sum} + {1'b0, word};
        m_sum = wide[31:0];
        if (wide[32]) m_ovf = 1'b1;
        check("acc_sum", sum, m_sum);
        check("out_valid_after_word", {31'd0, out_valid}, {31'd0, is_last});
    endtask

    task automatic finish_txn(input int delay);
        check("done_valid", {31'd0, out_valid}, 32'd1);
        check("done_sum", sum, m_sum);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        check_ovf("done_ovf");
        for (int d = 0; d < delay; d++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            len       = 8'd3;
            tick();
            start = 1'b0;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", sum, m_sum);
            check_ovf("hold_ovf");
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_sum_held", sum, m_sum);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"}, sum, 32'd0);
        check({tag, "_flags"}, {28'd0, in_ready, out_valid, busy, 1'b0}, 32'd0);
`ifdef SUM_ACCUM_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        m_sum = '0; m_ovf = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Two operands, immediate accept
        start_txn(2);
        feed(32'd65535, 0, 1'b0);
        feed(32'd11111, 0, 1'b1);
        check("r033_sum", sum, 32'd76646);
        finish_txn(0);

        // Gapped words; back-to-back start right after the handshake
        start_txn(3);
        feed(32'd1021201, 2, 1'b0);
        feed(32'd1457454, 2, 1'b0);
        feed(32'd6553500, 2, 1'b1);
        check("r034_sum", sum, 32'd9032155);
        finish_txn(1);

        // Wrap with carry-out
        start_txn(2);
        feed(32'hFFFF_FFFF, 0, 1'b0);
        feed(32'h0000_0002, 0, 1'b1);
        check("r035_sum", sum, 32'h0000_0001);
`ifdef SUM_ACCUM_OVF_EN
        check("r035_ovf", {31'd0, ovf}, 32'd1);
`endif
        finish_txn(0);

        // Zero-length request
        start_txn(0);
        finish_txn(2);

        // Reset mid-accumulation, then a fresh single-operand run
        start_txn(4);
        feed(32'd1234, 0, 1'b0);
        feed(32'd5678, 1, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        tick();
        check_all_zero("midrst_held");
        rst = 1'b0;
        start_txn(1);
        feed(32'd65455345, 0, 1'b1);
        check("r037_sum", sum, 32'd65455345);
        finish_txn(0);

        // Long out_ready stall with start pulsed during DONE
        start_txn(1);
        feed(32'd42, 0, 1'b1);
        finish_txn(5);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(0, 6);
            start_txn(n);
            for (int i = 0; i < n; i++) begin
                logic [31:0] w;
                w = ($urandom_range(0, 3) == 0) ? (32'hF000_0000 | $urandom) : $urandom;
                feed(w, $urandom_range(0, 2), i == n - 1);
            end
            finish_txn($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
